// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped input port.
// Defines the register word offsets, the INFO magic value and the default debounce length.
// Also provides a helper that builds the read-only INFO word.
package mmio_pkg;

    localparam logic [1:0]  MMIO_IN_SW   = 2'd0;
    localparam logic [1:0]  MMIO_IN_BTN  = 2'd1;
    localparam logic [1:0]  MMIO_IN_EDGE = 2'd2;
    localparam logic [1:0]  MMIO_IN_INFO = 2'd3;

    localparam logic [15:0] MMIO_IN_INFO_MAGIC = 16'h1A55;

    // 5 ms at 25 MHz
    localparam int MMIO_IN_DEBOUNCE_DEFAULT = 125000;

    // INFO word: the magic value in the upper half, then the button count, then the switch count.
    function automatic logic [31:0] info_word(input int num_btn, input int num_sw);
        logic [31:0] btn_v;
        logic [31:0] sw_v;
        btn_v = num_btn;
        sw_v  = num_sw;
        return {MMIO_IN_INFO_MAGIC, btn_v[7:0], sw_v[7:0]};
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Debouncer for a single asynchronous input bit.
// A 2-flop synchronizer feeds a stable-value register S and a mismatch counter C.
// The output stable_next is the value S takes at the next clock. The parent registers
// stable_next itself, so it sees an accepted change one cycle early and can flag edges
// in the same cycle that the level updates.
module input_debouncer
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = MMIO_IN_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;

    // A change is accepted after the synchronized value has differed from S for DEBOUNCE_CYCLES cycles.
    assign accept_s    = (sync2_r != stable_r) && (cnt_r == CNT_LAST);
    assign stable_next = accept_s ? sync2_r : stable_r;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Mismatch counter: restarts whenever the input returns to S; it updates S after a full stable run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else if (sync2_r == stable_r) begin
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s) begin
            stable_r <= sync2_r;
            cnt_r    <= {CW{1'b0}};
        end else begin
            cnt_r    <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped input port: debounced switches and buttons, with sticky button-edge capture.
// Read data is combinational from registered state, so a single-cycle core can sample it in the same cycle.
// data_out is zero unless this block is selected for a read, which lets peripheral buses be OR-combined.
// Optional build macro MMIO_INPUT_FALL_EDGE_EN adds falling-edge capture in EDGE[31:16].
// With this macro defined, NUM_BTN must be <= 16.
module mmio_input_port
    import mmio_pkg::*;
#(
    parameter int NUM_SW          = 16,
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = MMIO_IN_DEBOUNCE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic [3:0]         wbe,
    input  logic [1:0]         address,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_BTN-1:0] btn_raw
);

    localparam logic [31:0] RISE_MASK = 32'((64'd1 << NUM_BTN) - 64'd1);
`ifdef MMIO_INPUT_FALL_EDGE_EN
    localparam logic [31:0] EDGE_MASK = RISE_MASK | (RISE_MASK << 16);
`else
    localparam logic [31:0] EDGE_MASK = RISE_MASK;
`endif

    logic [NUM_SW-1:0]  sw_next_s;
    logic [NUM_BTN-1:0] btn_next_s;
    logic [NUM_SW-1:0]  sw_stable_r;
    logic [NUM_BTN-1:0] btn_stable_r;
    logic [31:0]        edge_r;
    logic [31:0]        set_word_s;
    logic [31:0]        clr_word_s;
    logic               edge_wr_s;
    logic [31:0]        rd_data_s;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (sw_raw[i]),
            .stable_next (sw_next_s[i])
        );
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (btn_raw[i]),
            .stable_next (btn_next_s[i])
        );
    end

    // Accepted levels. These duplicate the debouncer S flops so that edges are visible one cycle ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable_r  <= {NUM_SW{1'b0}};
            btn_stable_r <= {NUM_BTN{1'b0}};
        end else begin
            sw_stable_r  <= sw_next_s;
            btn_stable_r <= btn_next_s;
        end
    end

    assign edge_wr_s = ce && (wbe != 4'b0000) && (address == MMIO_IN_EDGE);

    // Edge set pulses land on the same clock as the level change; write-one clear mask from the core.
    always_comb begin
        set_word_s = 32'(btn_next_s & ~btn_stable_r);
`ifdef MMIO_INPUT_FALL_EDGE_EN
        set_word_s = set_word_s | (32'(btn_stable_r & ~btn_next_s) << 16);
`endif
        if (edge_wr_s) begin
            clr_word_s = data_in;
        end else begin
            clr_word_s = 32'h0000_0000;
        end
    end

    // Sticky edge flags: the clear is applied first, so a set in the same cycle wins. Unimplemented bits stay 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_r <= 32'h0000_0000;
        end else begin
            edge_r <= ((edge_r & ~clr_word_s) | set_word_s) & EDGE_MASK;
        end
    end

    // Read mux: drives data only for a selected read, otherwise 0.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (ce && (wbe == 4'b0000)) begin
            case (address)
                MMIO_IN_SW:   rd_data_s = 32'(sw_stable_r);
                MMIO_IN_BTN:  rd_data_s = 32'(btn_stable_r);
                MMIO_IN_EDGE: rd_data_s = edge_r;
                MMIO_IN_INFO: rd_data_s = info_word(NUM_BTN, NUM_SW);
                default:      rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    assign data_out = rd_data_s;

endmodule

// File: tb/tb_mmio_input_port.sv
// Scoreboard bench for mmio_input_port (DEBOUNCE_CYCLES=4, NUM_SW=16, NUM_BTN=5).
// The driver pushes a hand-computed expected data_out for each checked cycle.
// A monitor on the falling clock edge pops each expected value and compares it with data_out.
module tb_mmio_input_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [3:0]  wbe;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [15:0] sw_raw;
    logic [4:0]  btn_raw;

    logic        chk_en;
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;

`ifdef MMIO_INPUT_FALL_EDGE_EN
    localparam logic [31:0] FALL0 = 32'h0001_0000;
`else
    localparam logic [31:0] FALL0 = 32'h0000_0000;
`endif

    mmio_input_port #(.NUM_SW(16), .NUM_BTN(5), .DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .wbe      (wbe),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .sw_raw   (sw_raw),
        .btn_raw  (btn_raw)
    );

    always #5 clk = ~clk;

    // Monitor: compare data_out with the next expected value in every checked cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        string       n;
        if (chk_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got %h with no expected value", data_out);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, data_out, e);
                end
            end
        end
    end

    task automatic do_check(input logic ce_v, input logic [3:0] wbe_v, input logic [1:0] a,
                            input logic [31:0] d, input logic [31:0] e, input string n);
        @(posedge clk);
        #1;
        ce      = ce_v;
        wbe     = wbe_v;
        address = a;
        data_in = d;
        exp_q.push_back(e);
        name_q.push_back(n);
        chk_en  = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ce      = 1'b0;
            wbe     = 4'h0;
            data_in = 32'h0;
            chk_en  = 1'b0;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ce      = 1'b0;
        wbe     = 4'h0;
        address = 2'd0;
        data_in = 32'h0;
        sw_raw  = 16'hFFFF;
        btn_raw = 5'b00000;
        chk_en  = 1'b0;

        // Reset: all registers read 0 while the switches are held high.
        idle(2);
        do_check(1'b1, 4'h0, 2'd0, 32'h0, 32'h0, "rst_sw");
        do_check(1'b1, 4'h0, 2'd1, 32'h0, 32'h0, "rst_btn");
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h0, "rst_edge");
        idle(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            do_check(1'b1, 4'h0, 2'd0, 32'h0, (k == 6) ? 32'h0000_FFFF : 32'h0, $sformatf("sw_latency_%0d", k));
        end
        idle(1);

        // Glitch of 3 cycles on btn0 is rejected.
        btn_raw = 5'b00001;
        for (int k = 1; k <= 3; k++) begin
            do_check(1'b1, 4'h0, 2'd1, 32'h0, 32'h0, $sformatf("glitch_btn_%0d", k));
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 6; k++) begin
            do_check(1'b1, 4'h0, (k % 2 == 0) ? 2'd2 : 2'd1, 32'h0, 32'h0, $sformatf("glitch_after_%0d", k));
        end
        idle(1);

        // Held press: BTN and EDGE appear 6 cycles after the pin rises.
        btn_raw = 5'b00001;
        for (int k = 1; k <= 5; k++) begin
            do_check(1'b1, 4'h0, 2'd1, 32'h0, 32'h0, $sformatf("press_btn_%0d", k));
        end
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h1, "press_edge_6");
        do_check(1'b1, 4'h0, 2'd1, 32'h0, 32'h1, "press_btn_7");
        idle(1);

        // Write-one-to-clear on EDGE; writes to SW have no effect.
        btn_raw = 5'b10101;
        idle(8);
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h15, "edge_10101");
        do_check(1'b1, 4'hF, 2'd2, 32'h1, 32'h0, "w1c_write_bus");
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h14, "w1c_cleared");
        do_check(1'b1, 4'h3, 2'd0, 32'hFFFF_FFFF, 32'h0, "sw_write_bus");
        do_check(1'b1, 4'h0, 2'd0, 32'h0, 32'h0000_FFFF, "sw_after_write");
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h14, "edge_after_sw_write");
        do_check(1'b1, 4'h1, 2'd2, 32'h0, 32'h0, "w1c_zero_write");
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h14, "edge_after_zero_write");
        do_check(1'b1, 4'h0, 2'd1, 32'h0, 32'h15, "btn_10101");
        idle(1);

        // Bus behaviour and INFO.
        do_check(1'b0, 4'h0, 2'd3, 32'h0, 32'h0, "ce_low");
        do_check(1'b1, 4'h0, 2'd3, 32'h0, 32'h1A55_0510, "info");
        do_check(1'b1, 4'h2, 2'd3, 32'hFFFF_FFFF, 32'h0, "info_write_bus");
        do_check(1'b1, 4'h0, 2'd3, 32'h0, 32'h1A55_0510, "info_after_write");
        idle(1);

        // Release btn2, then clear its edge bits (fall bit 18 too when present).
        btn_raw = 5'b10001;
        idle(8);
        do_check(1'b1, 4'hF, 2'd2, 32'h0004_0004, 32'h0, "clr2_write");
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h10, "clr2_edge");
        do_check(1'b1, 4'h0, 2'd1, 32'h0, 32'h11, "btn_10001");
        idle(1);

        // Collision: clear bit 2 in the same cycle that btn_stable[2] rises; the set wins.
        btn_raw = 5'b10101;
        idle(4);
        do_check(1'b1, 4'hF, 2'd2, 32'h4, 32'h0, "collision_write");
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h14, "collision_edge");
        do_check(1'b1, 4'h0, 2'd1, 32'h0, 32'h15, "collision_btn");
        idle(1);

        // Release and re-press btn0; fall capture only when enabled. Clearing bit 16 leaves the rise bits.
        btn_raw = 5'b10100;
        idle(8);
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h14 | FALL0, "release0_edge");
        idle(1);
        btn_raw = 5'b10101;
        idle(8);
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h15 | FALL0, "repress0_edge");
        do_check(1'b1, 4'hF, 2'd2, 32'h0001_0000, 32'h0, "clr16_write");
        do_check(1'b1, 4'h0, 2'd2, 32'h0, 32'h15, "clr16_edge");
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
